// File: rtl/sudoku_input_ctrl.sv
// Sudoku keyboard-command sequencer: cursor moves, read-check-write of a cell, and the solution checker handshake.
// Optional CURSOR_WRAP_EN: cursor wraps 8<->0 instead of saturating.
module sudoku_input_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_up,
    input  logic       cmd_down,
    input  logic       cmd_left,
    input  logic       cmd_right,
    input  logic       cmd_enter,
    input  logic [3:0] cmd_number,
    input  logic       cmd_valid,
    output logic [3:0] cursor_row,
    output logic [3:0] cursor_col,
    output logic [6:0] mem_addr,
    output logic       mem_rd,
    input  logic [4:0] mem_rd_data,
    output logic       mem_wr,
    output logic [3:0] mem_wr_data,
    output logic       chk_start,
    input  logic       chk_done,
    input  logic       chk_solved,
    output logic       busy,
    output logic       solved,
    output logic       reject
);

    localparam logic [3:0] MAX_IDX = 4'd8;

    typedef enum logic [2:0] {IDLE, RD, RD_DATA, WR, CHK, CHK_WAIT} state_t;

    state_t state;

    function automatic logic [3:0] step_inc(input logic [3:0] v);
`ifdef CURSOR_WRAP_EN
        return (v >= MAX_IDX) ? 4'd0 : v + 4'd1;
`else
        return (v >= MAX_IDX) ? MAX_IDX : v + 4'd1;
`endif
    endfunction

    function automatic logic [3:0] step_dec(input logic [3:0] v);
`ifdef CURSOR_WRAP_EN
        return (v == 4'd0) ? MAX_IDX : v - 4'd1;
`else
        return (v == 4'd0) ? 4'd0 : v - 4'd1;
`endif
    endfunction

    function automatic logic [6:0] cell_index(input logic [3:0] row, input logic [3:0] col);
        return 7'(row) * 7'd9 + 7'(col);
    endfunction

    logic digit_ok;
    assign digit_ok = (cmd_number != 4'd0) && (cmd_number <= 4'd9);
    assign busy     = (state != IDLE);

    // mem_addr tracks the cursor; the cursor is frozen while busy, so the address holds for the whole access.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cursor_row  <= 4'd0;
            cursor_col  <= 4'd0;
            mem_addr    <= 7'd0;
            mem_wr_data <= 4'd0;
            mem_rd      <= 1'b0;
            mem_wr      <= 1'b0;
            chk_start   <= 1'b0;
            reject      <= 1'b0;
            solved      <= 1'b0;
        end else begin
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            chk_start <= 1'b0;
            reject    <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_up) begin
                            cursor_row <= step_dec(cursor_row);
                            mem_addr   <= cell_index(step_dec(cursor_row), cursor_col);
                        end else if (cmd_down) begin
                            cursor_row <= step_inc(cursor_row);
                            mem_addr   <= cell_index(step_inc(cursor_row), cursor_col);
                        end else if (cmd_left) begin
                            cursor_col <= step_dec(cursor_col);
                            mem_addr   <= cell_index(cursor_row, step_dec(cursor_col));
                        end else if (cmd_right) begin
                            cursor_col <= step_inc(cursor_col);
                            mem_addr   <= cell_index(cursor_row, step_inc(cursor_col));
                        end else if (cmd_enter) begin
                            chk_start <= 1'b1;
                            state     <= CHK;
                        end else if (digit_ok) begin
                            mem_wr_data <= cmd_number;
                            mem_addr    <= cell_index(cursor_row, cursor_col);
                            mem_rd      <= 1'b1;
                            state       <= RD;
                        end
                    end
                end
                RD: state <= RD_DATA;
                RD_DATA: begin
                    // Fixed clue cells and an already-solved board refuse the write.
                    if (mem_rd_data[4] || solved) begin
                        reject <= 1'b1;
                        state  <= IDLE;
                    end else begin
                        mem_wr <= 1'b1;
                        state  <= WR;
                    end
                end
                WR:  state <= IDLE;
                CHK: state <= CHK_WAIT;
                CHK_WAIT: begin
                    if (chk_done) begin
                        solved <= solved | chk_solved;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
